// File: rtl/rebnet_pkg.sv
// ---------------------------------------------------------------------------
// rebnet_pkg
// Shared types and sizing helpers for the activation buffers.
//   WORD_W / BEATS      : packed word width and beats per word at the default
//                         sizing (simd_width=32, pe_count=16, levels=2)
//   word_width()        : simd_width * binary_input_levels
//   beats_per_word()    : simd_width / pe_count
//   slice_lsb()         : LSB of slice idx when slices are width bits wide
//   buf_state_t         : write-side FSM states
// ---------------------------------------------------------------------------
package rebnet_pkg;

   localparam int unsigned WORD_W = 32 * 2;
   localparam int unsigned BEATS  = 32 / 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } buf_state_t;

   function automatic int unsigned word_width(input int unsigned simd_width,
                                              input int unsigned levels);
      return simd_width * levels;
   endfunction

   function automatic int unsigned beats_per_word(input int unsigned simd_width,
                                                  input int unsigned pe_count);
      return simd_width / pe_count;
   endfunction

   function automatic int unsigned slice_lsb(input int unsigned idx,
                                             input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/output_buffer_ram.sv
// ---------------------------------------------------------------------------
// output_buffer_ram
// Single-write / single-read synchronous RAM, 2^address_width x word_w.
// Read-first: a read and write of the same address on one edge returns the
// old contents. One-cycle read latency; rd_data holds when rd_en is low.
// Ports:
//   clk, rst            clock / async active-high reset (read register only)
//   wr_en, wr_addr, wr_data   write port
//   rd_en, rd_addr, rd_data   read port
// ---------------------------------------------------------------------------
module output_buffer_ram #(
   parameter int unsigned address_width = 12,
   parameter int unsigned word_w        = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [address_width-1:0] wr_addr,
   input  logic [word_w-1:0]        wr_data,
   input  logic                     rd_en,
   input  logic [address_width-1:0] rd_addr,
   output logic [word_w-1:0]        rd_data
);

   logic [word_w-1:0] mem [2**address_width];

   // Storage array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Non-blocking read of the array on the same edge gives read-first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/output_buffer.sv
// ---------------------------------------------------------------------------
// output_buffer
// Packs PE-array activation beats (pe_count lanes x binary_input_levels bits)
// into simd_width x binary_input_levels words, stores them in a word RAM and
// serves them back to the next layer by address.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           pulse: clear pointers, begin (or restart) an image
//   in_valid/in_data/in_last/in_ready   beat input handshake
//   enable/address  read request; data/ready one cycle later
//   words_written   committed word count
//   done            image complete, held until start or rst
// ---------------------------------------------------------------------------
module output_buffer #(
   parameter int unsigned address_width       = 12,
   parameter int unsigned depth               = 18,
   parameter int unsigned simd_width          = 32,
   parameter int unsigned pe_count            = 16,
   parameter int unsigned binary_input_levels = 2
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic                                        in_valid,
   input  logic [pe_count*binary_input_levels-1:0]     in_data,
   input  logic                                        in_last,
   output logic                                        in_ready,
   input  logic                                        enable,
   input  logic [address_width-1:0]                    address,
   output logic [simd_width*binary_input_levels-1:0]   data,
   output logic                                        ready,
   output logic [address_width:0]                      words_written,
   output logic                                        done
);

   import rebnet_pkg::*;

   localparam int unsigned WORD_BITS  = word_width(simd_width, binary_input_levels);
   localparam int unsigned BEAT_COUNT = beats_per_word(simd_width, pe_count);
   localparam int unsigned BEAT_W     = pe_count * binary_input_levels;
   localparam int unsigned CNT_W      = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
   localparam logic [address_width:0] DEPTH_CNT = (address_width + 1)'(depth);

   buf_state_t                 state;
   logic [CNT_W-1:0]           beat_cnt;
   logic [address_width-1:0]   wr_ptr;
   logic [WORD_BITS-1:0]       pack_reg;
   logic [WORD_BITS-1:0]       wr_word;
   logic                       accept;
   logic                       beat_last;
   logic                       wr_en;
   logic                       rd_oob;
   logic [WORD_BITS-1:0]       ram_rd_data;

   // start takes priority over a coincident beat; that beat is dropped.
   assign accept    = in_valid && in_ready && (state == FILL) && !start;
   assign beat_last = (32'(beat_cnt) == BEAT_COUNT - 1);
   assign wr_en     = accept && (beat_last || in_last);

   // Word as it stands after this beat: earlier beats from pack_reg, the
   // current beat in its slot, later slots zero (padding for a short tail).
   always_comb begin
      wr_word = '0;
      for (int unsigned k = 0; k < BEAT_COUNT; k++) begin
         if (k < 32'(beat_cnt)) begin
            wr_word[slice_lsb(k, BEAT_W) +: BEAT_W] = pack_reg[slice_lsb(k, BEAT_W) +: BEAT_W];
         end else if (k == 32'(beat_cnt)) begin
            wr_word[slice_lsb(k, BEAT_W) +: BEAT_W] = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         in_ready      <= 1'b0;
         done          <= 1'b0;
         beat_cnt      <= '0;
         wr_ptr        <= '0;
         words_written <= '0;
         pack_reg      <= '0;
      end else if (start) begin
         // Covers IDLE start, DONE restart and FILL abort alike.
         state         <= FILL;
         in_ready      <= 1'b1;
         done          <= 1'b0;
         beat_cnt      <= '0;
         wr_ptr        <= '0;
         words_written <= '0;
         pack_reg      <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b0;
               done     <= 1'b0;
            end
            FILL: begin
               if (accept) begin
                  if (wr_en) begin
                     pack_reg      <= '0;
                     beat_cnt      <= '0;
                     wr_ptr        <= wr_ptr + 1'b1;
                     words_written <= words_written + 1'b1;
                     if (in_last || (words_written + 1'b1 == DEPTH_CNT)) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                     end
                  end else begin
                     pack_reg <= wr_word;
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               in_ready <= 1'b0;
               done     <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

   output_buffer_ram #(
      .address_width (address_width),
      .word_w        (WORD_BITS)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_word),
      .rd_en   (enable),
      .rd_addr (address),
      .rd_data (ram_rd_data)
   );

   // Out-of-range flag is captured with the request so data holds with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready  <= 1'b0;
         rd_oob <= 1'b0;
      end else begin
         ready <= enable;
         if (enable) begin
            rd_oob <= ({1'b0, address} >= DEPTH_CNT);
         end
      end
   end

   assign data = rd_oob ? '0 : ram_rd_data;

endmodule

// File: tb/tb_output_buffer.sv
module tb_output_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_ready;
   logic        enable;
   logic [11:0] address;
   logic [63:0] data;
   logic        ready;
   logic [12:0] words_written;
   logic        done;

   int tests_run    = 0;
   int tests_failed = 0;

   output_buffer #(
      .address_width       (12),
      .depth               (18),
      .simd_width          (32),
      .pe_count            (16),
      .binary_input_levels (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .enable        (enable),
      .address       (address),
      .data          (data),
      .ready         (ready),
      .words_written (words_written),
      .done          (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         tests_run++;
         tests_failed++;
         $display("FAIL beat_handshake: in_ready got 0 required 1 within 20 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_read(input logic [11:0] a, output logic [63:0] d, output logic r);
      enable  = 1'b1;
      address = a;
      @(posedge clk); #1;
      enable = 1'b0;
      d = data;
      r = ready;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      enable = 1'b0; address = '0;
      #150;
      tests_run++;
      if (in_ready !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: in_ready=%b done=%b ready=%b required 0 0 0", in_ready, done, ready);
      end
      tests_run++;
      if (data !== 64'h0 || words_written !== 13'd0) begin
         tests_failed++;
         $display("FAIL reset_values: data=%h words_written=%0d required 0 0", data, words_written);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_hold: in_ready=%b done=%b required 0 0", in_ready, done);
      end
   endtask

   task automatic test_full_image();
      logic [63:0] d;
      logic r;
      do_start();
      tests_run++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_fill_entry: in_ready=%b done=%b required 1 0", in_ready, done);
      end
      for (int i = 0; i < 36; i++) send_beat(32'(i), (i == 35));
      tests_run++;
      if (words_written !== 13'd18 || done !== 1'b1 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_complete: words_written=%0d done=%b in_ready=%b required 18 1 0",
                  words_written, done, in_ready);
      end
      do_read(12'd2, d, r);
      tests_run++;
      if (r !== 1'b1 || d !== 64'h0000_0005_0000_0004) begin
         tests_failed++;
         $display("FAIL full_read2: ready=%b data=%h required 1 0000000500000004", r, d);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ready !== 1'b0 || data !== 64'h0000_0005_0000_0004) begin
         tests_failed++;
         $display("FAIL full_ready_pulse: ready=%b data=%h required 0 0000000500000004", ready, data);
      end
      do_read(12'd17, d, r);
      tests_run++;
      if (r !== 1'b1 || d !== 64'h0000_0023_0000_0022) begin
         tests_failed++;
         $display("FAIL full_read17: ready=%b data=%h required 1 0000002300000022", r, d);
      end
   endtask

   task automatic test_partial();
      logic [63:0] d;
      logic r;
      do_start();
      tests_run++;
      if (done !== 1'b0 || words_written !== 13'd0) begin
         tests_failed++;
         $display("FAIL partial_restart: done=%b words_written=%0d required 0 0", done, words_written);
      end
      send_beat(32'hA, 1'b0);
      send_beat(32'hB, 1'b0);
      send_beat(32'hC, 1'b1);
      tests_run++;
      if (words_written !== 13'd2 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL partial_count: words_written=%0d done=%b required 2 1", words_written, done);
      end
      do_read(12'd1, d, r);
      tests_run++;
      if (r !== 1'b1 || d !== 64'h0000_0000_0000_000C) begin
         tests_failed++;
         $display("FAIL partial_pad: ready=%b data=%h required 1 000000000000000c", r, d);
      end
      do_read(12'd0, d, r);
      tests_run++;
      if (d !== 64'h0000_000B_0000_000A) begin
         tests_failed++;
         $display("FAIL partial_word0: data=%h required 0000000b0000000a", d);
      end
   endtask

   task automatic test_read_corners();
      logic [63:0] d;
      logic r;
      do_read(12'd18, d, r);
      tests_run++;
      if (r !== 1'b1 || d !== 64'h0) begin
         tests_failed++;
         $display("FAIL read_oob: ready=%b data=%h required 1 0", r, d);
      end
      // Word 0 currently holds {B, A}; overwrite it while reading it.
      do_start();
      send_beat(32'h77, 1'b0);
      in_valid = 1'b1; in_data = 32'h88; in_last = 1'b0;
      enable = 1'b1; address = 12'd0;
      @(posedge clk); #1;
      in_valid = 1'b0; enable = 1'b0;
      tests_run++;
      if (ready !== 1'b1 || data !== 64'h0000_000B_0000_000A) begin
         tests_failed++;
         $display("FAIL read_first: ready=%b data=%h required 1 0000000b0000000a", ready, data);
      end
      do_read(12'd0, d, r);
      tests_run++;
      if (d !== 64'h0000_0088_0000_0077) begin
         tests_failed++;
         $display("FAIL read_after_write: data=%h required 0000008800000077", d);
      end
   endtask

   task automatic test_overflow();
      logic [63:0] d;
      logic r;
      do_start();
      for (int i = 0; i < 36; i++) send_beat(32'h100 + 32'(i), 1'b0);
      tests_run++;
      if (done !== 1'b1 || in_ready !== 1'b0 || words_written !== 13'd18) begin
         tests_failed++;
         $display("FAIL overflow_stop: done=%b in_ready=%b words_written=%0d required 1 0 18",
                  done, in_ready, words_written);
      end
      for (int i = 36; i < 40; i++) begin
         in_valid = 1'b1; in_data = 32'hFFFF_0000 + 32'(i); in_last = 1'b0;
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      tests_run++;
      if (done !== 1'b1 || in_ready !== 1'b0 || words_written !== 13'd18) begin
         tests_failed++;
         $display("FAIL overflow_ignore: done=%b in_ready=%b words_written=%0d required 1 0 18",
                  done, in_ready, words_written);
      end
      do_read(12'd0, d, r);
      tests_run++;
      if (d !== 64'h0000_0101_0000_0100) begin
         tests_failed++;
         $display("FAIL overflow_word0: data=%h required 0000010100000100", d);
      end
      do_read(12'd17, d, r);
      tests_run++;
      if (d !== 64'h0000_0123_0000_0122) begin
         tests_failed++;
         $display("FAIL overflow_word17: data=%h required 0000012300000122", d);
      end
   endtask

   task automatic test_abort();
      logic [63:0] d;
      logic r;
      do_start();
      for (int i = 0; i < 5; i++) send_beat(32'h300 + 32'(i), 1'b0);
      tests_run++;
      if (words_written !== 13'd2) begin
         tests_failed++;
         $display("FAIL abort_before: words_written=%0d required 2", words_written);
      end
      do_start();
      tests_run++;
      if (words_written !== 13'd0 || done !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_clear: words_written=%0d done=%b in_ready=%b required 0 0 1",
                  words_written, done, in_ready);
      end
      for (int i = 0; i < 36; i++) send_beat(32'h200 + 32'(i), (i == 35));
      tests_run++;
      if (words_written !== 13'd18 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_reimage: words_written=%0d done=%b required 18 1", words_written, done);
      end
      do_read(12'd0, d, r);
      tests_run++;
      if (d !== 64'h0000_0201_0000_0200) begin
         tests_failed++;
         $display("FAIL abort_word0: data=%h required 0000020100000200", d);
      end
      do_read(12'd3, d, r);
      tests_run++;
      if (d !== 64'h0000_0207_0000_0206) begin
         tests_failed++;
         $display("FAIL abort_word3: data=%h required 0000020700000206", d);
      end
   endtask

   task automatic test_async_reset();
      do_start();
      for (int i = 0; i < 3; i++) send_beat(32'h400 + 32'(i), 1'b0);
      #3;
      rst = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || words_written !== 13'd0 || data !== 64'h0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: in_ready=%b words_written=%0d data=%h done=%b required 0 0 0 0",
                  in_ready, words_written, data, done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_idle: in_ready=%b done=%b required 0 0", in_ready, done);
      end
   endtask

   initial begin
      test_reset();
      test_full_image();
      test_partial();
      test_read_corners();
      test_overflow();
      test_abort();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Write-side counterpart of the input activation buffer: accepts per-beat PE activation slices (pe_count lanes × binary_input_levels bits) and packs them into simd_width×binary_input_levels-bit words.
- Stores packed words into an internal word RAM and lets the next layer read them back by address with the same enable/address/data/ready style.
- Sits between the PE array output and the next layer's activation memory.

Parameters:
- address_width, 12, word address width of the internal RAM
- depth, 18, number of packed words per image (must be ≤ 2^address_width)
- simd_width, 32, activations per packed word
- pe_count, 16, activations delivered per input beat; simd_width % pe_count must be 0
- binary_input_levels, 2, bits per activation (residual binarization levels)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: clear pointers, begin a new image
- in_valid  in  1  input beat valid
- in_data  in  pe_count*binary_input_levels  beat payload; lane i occupies bits [i*L +: L], L = binary_input_levels
- in_last  in  1  qualifies the final beat of the image
- in_ready  out  1  buffer accepts a beat this cycle
- enable  in  1  read request
- address  in  address_width  read word address
- data  out  simd_width*binary_input_levels  read word
- ready  out  1  data valid; one-cycle pulse
- words_written  out  address_width+1  count of committed words
- done  out  1  image complete; level until start or rst

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=0, ready=0, data=0, done=0, words_written=0, beat_cnt=0, shift register=0. RAM contents are not cleared.
- Constants:
  - BEATS = simd_width/pe_count
  - WORD_W = simd_width*binary_input_levels
- FSM states: IDLE, FILL, DONE.
  - IDLE: in_ready=0. start → FILL next cycle, with beat_cnt=0, wr_ptr=0, words_written=0, done=0.
  - FILL: in_ready=1. A beat is accepted when in_valid&in_ready.
    - Beat k of a word goes to bits [k*pe_count*L +: pe_count*L] of the pack register.
    - When beat_cnt==BEATS-1, the assembled word is written to RAM[wr_ptr] at that same clock edge. Then wr_ptr++, words_written++, beat_cnt=0.
  - Accepted beat with in_last=1 and partial word (beat_cnt<BEATS-1): the remaining lanes are zero-padded and the word is written in the same edge.
  - Transition FILL → DONE when in_last is accepted, or when words_written reaches depth. Any write-side signal reaching depth also forces DONE.
  - DONE: in_ready=0, done=1. Further in_valid is ignored (no stall, no write). start → FILL (restart).
  - start while in FILL: abort. Pointers are cleared the next cycle and the partial word is discarded.
- Read port, any state:
  - enable=1 at edge t → ready=1 and data=RAM[address] at edge t+1 (latency 1). ready is low otherwise; data holds its last value.
  - address ≥ depth → data=0, ready=1.
  - Read and write to the same address in the same cycle → read returns the old contents (read-first).
- Reset asserted mid-image: immediate return to IDLE, all outputs at reset values; the image must be restarted with start.
- Word widths are exact; no sign or arithmetic on the payload.

Decomposition:
- Shared package (rebnet_pkg):
  - WORD_W, BEATS, lane-slice localparam function
  - state enum {IDLE, FILL, DONE}
- One sub-module: output_buffer_ram, a single-write/single-read synchronous RAM, read-first, 1-cycle read latency, depth 2^address_width × WORD_W.
- The FSM, pack register and counters stay in the top.

Test Plan:
- Reset then idle: rst high 150 ns → in_ready=0, done=0, ready=0, data=0, words_written=0.
- Full image, defaults (BEATS=2):
  - Stimulus: start, then 36 beats with in_data = beat index; in_last on beat 35.
  - Required: words_written=18, done=1.
  - Required: read address 2 → ready at +1 cycle, data = {32'h5, 32'h4}.
- Partial word: start, 3 beats (0xA, 0xB, 0xC with in_last) → words_written=2, RAM[1] = {32'h0, 32'hC}, done=1.
- Overflow:
  - Stimulus: 40 beats without in_last.
  - Required: after beat 36, done=1 and in_ready=0; words_written stays 18; beats 37–40 change nothing.
- Read corner cases:
  - enable with address=18 → ready=1, data=0.
  - Same-cycle read and write of word 0 → the old value is returned.
- Mid-image abort: start after 5 beats → words_written=0 next cycle; a fresh image of 36 beats completes correctly. Async rst mid-FILL → in_ready drops before the next clock edge.
